// File: rtl/spi_flash_responder_pkg.sv
// Shared opcodes, frame lengths and state encoding for the SPI flash read-path responder.
package spi_flash_responder_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_WAKE = 8'hAB;

  localparam int CMD_BITS  = 8;
  localparam int ADDR_BITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    IGNORE
  } state_e;

endpackage

// File: rtl/spi_flash_responder_edge_sync.sv
// Synchroniser and SCLK edge detector for SPI target inputs; edge pulses are one clk wide.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_cs,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic cs_n,
  output logic mosi,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   sclk_prev_q;

  // Chains reset to the bus idle levels: deselected, clock low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_q        <= '1;
      sclk_q      <= '0;
      mosi_q      <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_q        <= {cs_q[SYNC_STAGES-2:0], spi_cs};
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_q      <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign cs_n      = cs_q[SYNC_STAGES-1];
  assign mosi      = mosi_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 target emulating a serial flash read path (READ 0x03) backed by a synchronous byte memory.
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_cs,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              active
);

  localparam int SW = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [SW-1:0] SETTLED = SW'(SYNC_STAGES);

  logic cs_n_s, mosi_s, sclk_rise_s, sclk_fall_s;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_cs    (spi_cs),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .cs_n      (cs_n_s),
    .mosi      (mosi_s),
    .sclk_rise (sclk_rise_s),
    .sclk_fall (sclk_fall_s)
  );

  state_e            state_q;
  logic [22:0]       shift_q;
  logic [4:0]        bit_cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        out_byte_q;
  logic              miso_q, oe_q, mem_rd_q, rd_dly_q, active_q, armed_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [SW-1:0]     settle_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      out_byte_q <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      mem_rd_q   <= 1'b0;
      rd_dly_q   <= 1'b0;
      active_q   <= 1'b0;
      armed_q    <= 1'b0;
      mem_addr_q <= '0;
      settle_q   <= '0;
    end else begin
      mem_rd_q <= 1'b0;
      rd_dly_q <= mem_rd_q;
      if (settle_q != SETTLED) settle_q <= settle_q + 1'b1;
      // Read data lands the cycle after the strobe; dropped once deselected.
      if (rd_dly_q && state_q == DATA) out_byte_q <= mem_rdata;

      if (state_q != IDLE && cs_n_s) begin
        state_q  <= IDLE;
        active_q <= 1'b0;
        oe_q     <= 1'b0;
        miso_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            // A CS already low when reset is released must go high before it counts.
            if (cs_n_s && settle_q == SETTLED) armed_q <= 1'b1;
            if (!cs_n_s && armed_q) begin
              state_q   <= CMD;
              bit_cnt_q <= '0;
              active_q  <= 1'b1;
            end
          end
          CMD: if (sclk_rise_s) begin
            shift_q   <= {shift_q[21:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 5'(CMD_BITS - 1)) begin
              bit_cnt_q <= '0;
              case ({shift_q[6:0], mosi_s})
                OP_READ: state_q <= ADDR;
                OP_WAKE: state_q <= IGNORE;
                default: state_q <= IGNORE;
              endcase
            end
          end
          ADDR: if (sclk_rise_s) begin
            shift_q   <= {shift_q[21:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
              mem_addr_q <= ADDR_W'({shift_q, mosi_s});
              mem_rd_q   <= 1'b1;
              bit_idx_q  <= 3'd7;
              state_q    <= DATA;
            end
          end
          DATA: if (sclk_fall_s) begin
            oe_q      <= 1'b1;
            miso_q    <= out_byte_q[bit_idx_q];
            bit_idx_q <= bit_idx_q - 1'b1;
            // Last bit is out: prefetch the next byte well before its first fall.
            if (bit_idx_q == 3'd0) begin
              mem_addr_q <= mem_addr_q + 1'b1;
              mem_rd_q   <= 1'b1;
            end
          end
          IGNORE: begin
            oe_q   <= 1'b0;
            miso_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign active      = active_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder against a byte memory holding mem[i] = i ^ 8'h5A.
module tb_spi_flash_responder;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe, mem_rd, active;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'hEE;

  int n_checks = 0;
  int n_fail = 0;
  int rd_total = 0;
  int oe_total = 0;
  logic        wrap_seen = 1'b0;
  logic [15:0] last_rd_addr = 16'h0;

  spi_flash_responder #(.ADDR_W(16), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_cs      (spi_cs),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .active      (active)
  );

  always #5 clk = ~clk;

  // Byte memory with registered read; garbage outside the valid cycle.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem_addr[7:0] ^ 8'h5A;
      if (mem_addr == 16'h0000 && last_rd_addr == 16'hFFFF) wrap_seen <= 1'b1;
      last_rd_addr <= mem_addr;
      rd_total <= rd_total + 1;
    end else begin
      mem_rdata <= 8'hEE;
    end
    if (spi_miso_oe) oe_total <= oe_total + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Shifts the top nbits of tx out MSB first; rx holds MISO sampled at each rise.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      #HALF;
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      #HALF;
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send_read(input logic [23:0] addr);
    logic [7:0] rx;
    spi_byte(8'h03, 8, rx);
    spi_byte(addr[23:16], 8, rx);
    spi_byte(addr[15:8], 8, rx);
    spi_byte(addr[7:0], 8, rx);
  endtask

  task automatic cs_low;
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high;
    @(negedge clk);
    spi_cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    int rd_base, oe_base;
    logic [7:0] exp1 [4];
    exp1[0] = 8'h4A; exp1[1] = 8'h4B; exp1[2] = 8'h48; exp1[3] = 8'h49;

    repeat (4) @(negedge clk);
    check_val("rst_miso", spi_miso, 0);
    check_val("rst_oe", spi_miso_oe, 0);
    check_val("rst_mem_rd", mem_rd, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_active", active, 0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);

    // READ at 0x000010, four bytes
    rd_base = rd_total;
    cs_low();
    check_val("t1_active", active, 1);
    spi_byte(8'h03, 8, rx);
    spi_byte(8'h00, 8, rx);
    spi_byte(8'h00, 8, rx);
    spi_byte(8'h10, 7, rx);
    spi_mosi = 1'b0;
    #HALF;
    spi_sclk = 1'b1;
    #HALF;
    check_val("t1_oe_before_fall", spi_miso_oe, 0);
    spi_sclk = 1'b0;
    #40;
    check_val("t1_oe_after_fall", spi_miso_oe, 1);
    for (int b = 0; b < 4; b++) begin
      spi_byte(8'h00, 8, rx);
      check_val($sformatf("t1_byte%0d", b), rx, exp1[b]);
    end
    check_val("t1_rd_count", rd_total - rd_base, 5);
    check_val("t1_mem_addr", mem_addr, 16'h0014);
    cs_high();
    check_val("t1_active_off", active, 0);
    check_val("t1_oe_off", spi_miso_oe, 0);

    // Address wrap at 0xFFFF
    cs_low();
    send_read(24'h00FFFF);
    spi_byte(8'h00, 8, rx); check_val("t2_byte0", rx, 8'hA5);
    spi_byte(8'h00, 8, rx); check_val("t2_byte1", rx, 8'h5A);
    spi_byte(8'h00, 8, rx); check_val("t2_byte2", rx, 8'h5B);
    check_val("t2_wrap_seen", wrap_seen, 1);
    cs_high();

    // Release-power-down is ignored, then READ at 0
    rd_base = rd_total;
    oe_base = oe_total;
    cs_low();
    spi_byte(8'hAB, 8, rx);
    spi_byte(8'h00, 8, rx);
    cs_high();
    check_val("t3_wake_rd", rd_total - rd_base, 0);
    check_val("t3_wake_oe", oe_total - oe_base, 0);
    cs_low();
    send_read(24'h000000);
    spi_byte(8'h00, 8, rx); check_val("t3_byte0", rx, 8'h5A);
    cs_high();

    // Unknown opcode 0x9F plus 16 more clocks
    rd_base = rd_total;
    oe_base = oe_total;
    cs_low();
    spi_byte(8'h9F, 8, rx);
    spi_byte(8'hFF, 8, rx);
    spi_byte(8'h55, 8, rx);
    check_val("t4_active", active, 1);
    check_val("t4_rd", rd_total - rd_base, 0);
    check_val("t4_oe", oe_total - oe_base, 0);
    check_val("t4_miso", spi_miso, 0);
    @(negedge clk);
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    check_val("t4_active_drop", active, 0);
    repeat (4) @(negedge clk);

    // Abort after 12 address bits, then READ at 0x000002
    rd_base = rd_total;
    cs_low();
    spi_byte(8'h03, 8, rx);
    spi_byte(8'h00, 8, rx);
    spi_byte(8'h00, 4, rx);
    cs_high();
    check_val("t5_abort_rd", rd_total - rd_base, 0);
    cs_low();
    send_read(24'h000002);
    spi_byte(8'h00, 8, rx); check_val("t5_byte0", rx, 8'h58);
    check_val("t5_rd", rd_total - rd_base, 2);
    cs_high();

    // Reset during DATA byte 2 with CS held low
    cs_low();
    send_read(24'h000000);
    spi_byte(8'h00, 8, rx); check_val("t6_byte0", rx, 8'h5A);
    spi_byte(8'h00, 3, rx);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("t6_rst_miso", spi_miso, 0);
    check_val("t6_rst_oe", spi_miso_oe, 0);
    check_val("t6_rst_mem_rd", mem_rd, 0);
    check_val("t6_rst_mem_addr", mem_addr, 0);
    check_val("t6_rst_active", active, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    rd_base = rd_total;
    oe_base = oe_total;
    send_read(24'h000010);
    spi_byte(8'h00, 8, rx);
    check_val("t6_held_active", active, 0);
    check_val("t6_held_rd", rd_total - rd_base, 0);
    check_val("t6_held_oe", oe_total - oe_base, 0);
    cs_high();
    cs_low();
    send_read(24'h000010);
    spi_byte(8'h00, 8, rx); check_val("t6_byte_after", rx, 8'h4A);
    cs_high();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
